// File: rtl/sobel_edge_filter.sv
// -----------------------------------------------------------------------------
// sobel_edge_filter
//   Streaming 3x3 Sobel edge detector for the greyscale camera pixel path.
//   Each accepted pixel (iDVAL=1) shifts two line buffers and a 3x3 window.
//   One output pixel comes out per accepted pixel, a fixed 3 cycles later.
//   The output is one of: the window centre (bypass), |Gx|, |Gy| or |Gx|+|Gy|,
//   saturated to DATA_W bits, plus an edge flag compared against a threshold.
//
// Ports
//   iCLK     clock
//   iRST     asynchronous active-low reset
//   iSOF     start of frame: restarts column/row accounting, latches iMODE/iTHRESH
//   iDVAL    input pixel valid
//   iDATA    greyscale input pixel
//   iMODE    00 bypass, 01 |Gx|, 10 |Gy|, 11 |Gx|+|Gy|
//   iTHRESH  edge threshold
//   oDVAL    output pixel valid
//   oDATA    filtered pixel (0 while the window is incomplete at the frame border)
//   oEDGE    1 when oDATA >= threshold in a filter mode
// -----------------------------------------------------------------------------
module sobel_edge_filter #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int ROW_W  = 11
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSOF,
    input  logic              iDVAL,
    input  logic [DATA_W-1:0] iDATA,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iTHRESH,
    output logic              oDVAL,
    output logic [DATA_W-1:0] oDATA,
    output logic              oEDGE
);

    localparam int GW = DATA_W + 3;      // signed gradient width
    localparam int MW = DATA_W + 4;      // unsigned magnitude-sum width
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ROW_W-1:0] COL_LAST = ROW_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(2);

    typedef logic [DATA_W-1:0] pix_t;

    // Zero-extend a pixel into the signed gradient domain.
    function automatic logic signed [GW-1:0] extPix(input pix_t p);
        return $signed({3'b000, p});
    endfunction

    // Absolute value of a gradient, widened so |Gx|+|Gy| cannot wrap.
    function automatic logic [MW-1:0] absMag(input logic signed [GW-1:0] g);
        logic [GW-1:0] m;
        m = g[GW-1] ? GW'(-g) : GW'(g);
        return {1'b0, m};
    endfunction

    // Clamp a magnitude to the largest representable pixel.
    function automatic pix_t satPix(input logic [MW-1:0] v);
        return (|v[MW-1:DATA_W]) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
    endfunction

    // Column/row accounting and per-frame settings
    logic [ROW_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] colEff;
    logic [ROW_W-1:0] rowEff;
    logic [1:0]       modeLat;
    pix_t             threshLat;
    logic [AW-1:0]    lbAddr;

    // A pixel arriving with iSOF is column 0 of row 0 of the new frame.
    assign colEff = iSOF ? '0 : col;
    assign rowEff = iSOF ? '0 : row;
    assign lbAddr = colEff[AW-1:0];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col       <= '0;
            row       <= '0;
            modeLat   <= 2'b00;
            threshLat <= '0;
        end else begin
            if (iSOF) begin
                modeLat   <= iMODE;
                threshLat <= iTHRESH;
            end
            if (iDVAL) begin
                if (colEff == COL_LAST) begin
                    col <= '0;
                    // Only "at least two full rows seen" matters, so stop at 2.
                    row <= (rowEff >= ROW_FULL) ? ROW_FULL : rowEff + ROW_W'(1);
                end else begin
                    col <= colEff + ROW_W'(1);
                    row <= rowEff;
                end
            end else if (iSOF) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // Line buffers: lb1 holds the previous line, lb0 the line before that.
    // Not reset; stale contents only reach the window while the border tag
    // forces the output to zero.
    pix_t lb0 [IMG_W];
    pix_t lb1 [IMG_W];
    pix_t lbRd0;
    pix_t lbRd1;

    assign lbRd0 = lb0[lbAddr];
    assign lbRd1 = lb1[lbAddr];

    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lb0[lbAddr] <= lbRd1;
            lb1[lbAddr] <= iDATA;
        end
    end

    // ---- stage p0: window shift and border/mode tagging on accept ----
    pix_t       win [3][3];
    logic       vld_p0;
    logic       border_p0;
    logic [1:0] mode_p0;
    pix_t       thresh_p0;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            vld_p0    <= 1'b0;
            border_p0 <= 1'b1;
            mode_p0   <= 2'b00;
            thresh_p0 <= '0;
        end else begin
            vld_p0 <= iDVAL;
            if (iDVAL) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lbRd0;
                win[1][2] <= lbRd1;
                win[2][2] <= iDATA;
                border_p0 <= (rowEff < ROW_FULL) || (colEff < ROW_W'(2));
                mode_p0   <= iSOF ? iMODE : modeLat;
                thresh_p0 <= iSOF ? iTHRESH : threshLat;
            end
        end
    end

    logic signed [GW-1:0] gxC;
    logic signed [GW-1:0] gyC;

    always_comb begin
        gxC = (extPix(win[0][2]) + (extPix(win[1][2]) <<< 1) + extPix(win[2][2]))
            - (extPix(win[0][0]) + (extPix(win[1][0]) <<< 1) + extPix(win[2][0]));
        gyC = (extPix(win[2][0]) + (extPix(win[2][1]) <<< 1) + extPix(win[2][2]))
            - (extPix(win[0][0]) + (extPix(win[0][1]) <<< 1) + extPix(win[0][2]));
    end

    // ---- stage p1: gradients ----
    logic signed [GW-1:0] gx_p1;
    logic signed [GW-1:0] gy_p1;
    pix_t                 center_p1;
    logic                 vld_p1;
    logic                 border_p1;
    logic [1:0]           mode_p1;
    pix_t                 thresh_p1;

    always_ff @(posedge iCLK) begin
        gx_p1     <= gxC;
        gy_p1     <= gyC;
        center_p1 <= win[1][1];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            vld_p1    <= 1'b0;
            border_p1 <= 1'b1;
            mode_p1   <= 2'b00;
            thresh_p1 <= '0;
        end else begin
            vld_p1    <= vld_p0;
            border_p1 <= border_p0;
            mode_p1   <= mode_p0;
            thresh_p1 <= thresh_p0;
        end
    end

    logic [MW-1:0] absGx;
    logic [MW-1:0] absGy;
    logic [MW-1:0] magSel;
    pix_t          magC;

    always_comb begin
        absGx  = absMag(gx_p1);
        absGy  = absMag(gy_p1);
        magSel = absGx + absGy;
        case (mode_p1)
            2'b01:   magSel = absGx;
            2'b10:   magSel = absGy;
            default: magSel = absGx + absGy;
        endcase
        magC = satPix(magSel);
    end

    // ---- stage p2: magnitude, sum and saturation ----
    pix_t       mag_p2;
    pix_t       center_p2;
    logic       vld_p2;
    logic       border_p2;
    logic [1:0] mode_p2;
    pix_t       thresh_p2;

    always_ff @(posedge iCLK) begin
        mag_p2    <= magC;
        center_p2 <= center_p1;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            vld_p2    <= 1'b0;
            border_p2 <= 1'b1;
            mode_p2   <= 2'b00;
            thresh_p2 <= '0;
        end else begin
            vld_p2    <= vld_p1;
            border_p2 <= border_p1;
            mode_p2   <= mode_p1;
            thresh_p2 <= thresh_p1;
        end
    end

    // ---- output stage: mode select, border masking, threshold ----
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL <= 1'b0;
            oDATA <= '0;
            oEDGE <= 1'b0;
        end else begin
            oDVAL <= vld_p2;
            if (!vld_p2 || border_p2) begin
                oDATA <= '0;
                oEDGE <= 1'b0;
            end else if (mode_p2 == 2'b00) begin
                oDATA <= center_p2;
                oEDGE <= 1'b0;
            end else begin
                oDATA <= mag_p2;
                oEDGE <= (mag_p2 >= thresh_p2);
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// -----------------------------------------------------------------------------
// tb_sobel_edge_filter
//   Directed bench for sobel_edge_filter with IMG_W=8, DATA_W=12. Frames are
//   streamed from small image patterns; a frame-based Sobel model computes the
//   expected pixel and edge flag for every accepted pixel, and a monitor logs
//   every output pulse with its cycle so latency and order are checked too.
// -----------------------------------------------------------------------------
module tb_sobel_edge_filter;

    localparam int DW = 12;
    localparam int IW = 8;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iSOF = 1'b0;
    logic          iDVAL = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic [1:0]    iMODE = 2'b00;
    logic [DW-1:0] iTHRESH = '0;
    logic          oDVAL;
    logic [DW-1:0] oDATA;
    logic          oEDGE;

    sobel_edge_filter #(.DATA_W(DW), .IMG_W(IW), .ROW_W(11)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL), .iDATA(iDATA),
        .iMODE(iMODE), .iTHRESH(iTHRESH), .oDVAL(oDVAL), .oDATA(oDATA), .oEDGE(oEDGE)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int outD[$];
    int outE[$];
    int outC[$];
    int expD[$];
    int expE[$];
    int accC[$];
    int savedD[$];

    always @(negedge iCLK) begin
        if (oDVAL === 1'b1) begin
            outD.push_back(int'(oDATA));
            outE.push_back(int'(oEDGE));
            outC.push_back(cyc);
        end
    end

    int         img[8][8];
    int         br = 0;
    int         bc = 0;
    logic [1:0] modeT = 2'b00;
    int         thrT = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pat(input int id, input int r, input int c);
        case (id)
            0:       return r * IW + c;
            1:       return 500;
            2:       return (c < 4) ? 0 : 100;
            3:       return (c < 4) ? 0 : 4095;
            default: return (r * 811 + c * 1297 + 53) % 4096;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Frame-based reference: window rows r-2..r, columns c-2..c of this frame.
    function automatic void model(input int r, input int c, output int d, output int e);
        int p[3][3];
        int gx;
        int gy;
        int m;
        d = 0;
        e = 0;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    p[i][j] = img[r-2+i][c-2+j];
            gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
            gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
            case (modeT)
                2'b00:   m = p[1][1];
                2'b01:   m = iabs(gx);
                2'b10:   m = iabs(gy);
                default: m = iabs(gx) + iabs(gy);
            endcase
            d = (m > 4095) ? 4095 : m;
            e = (modeT != 2'b00 && d >= thrT) ? 1 : 0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iCLK);
            iDVAL = 1'b0;
            iSOF  = 1'b0;
        end
    endtask

    // Drives one pixel; between SOFs the mode/threshold inputs carry junk that
    // must be ignored by the design.
    task automatic sendPix(input bit sof, input int val, input bit rec, input int gapMax);
        int d;
        int e;
        @(negedge iCLK);
        if (sof) begin
            br = 0;
            bc = 0;
            iMODE   = modeT;
            iTHRESH = DW'(thrT);
        end else begin
            iMODE   = ~modeT;
            iTHRESH = ~DW'(thrT);
        end
        iSOF  = sof;
        iDVAL = 1'b1;
        iDATA = DW'(val);
        img[br][bc] = val;
        if (rec) begin
            model(br, bc, d, e);
            expD.push_back(d);
            expE.push_back(e);
            accC.push_back(cyc + 1);
        end
        bc++;
        if (bc == IW) begin
            bc = 0;
            br++;
        end
        idle($urandom_range(0, gapMax));
    endtask

    task automatic sendFrame(input logic [1:0] mode, input int thr, input int pid,
                             input int rows, input int gapMax);
        modeT = mode;
        thrT  = thr;
        for (int k = 0; k < rows * IW; k++)
            sendPix(k == 0, pat(pid, k / IW, k % IW), 1'b1, gapMax);
    endtask

    task automatic drainCompare(input string tag);
        int n;
        idle(8);
        chk($sformatf("%s_count", tag), outD.size(), expD.size());
        n = (outD.size() < expD.size()) ? outD.size() : expD.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_lat%0d", tag, i), outC[i] - accC[i], 3);
            chk($sformatf("%s_data%0d", tag, i), outD[i], expD[i]);
            chk($sformatf("%s_edge%0d", tag, i), outE[i], expE[i]);
        end
    endtask

    task automatic clearQ();
        outD.delete(); outE.delete(); outC.delete();
        expD.delete(); expE.delete(); accC.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        repeat (3) @(negedge iCLK);
        chk("rst_dval", int'(oDVAL), 0);
        chk("rst_data", int'(oDATA), 0);
        chk("rst_edge", int'(oEDGE), 0);
        iRST = 1'b1;
        idle(2);

        // 1: bypass ramp
        sendFrame(2'b00, 0, 0, 8, 0);
        drainCompare("t1");
        chk("t1_k9_border", outD[9], 0);
        chk("t1_k18", outD[18], 9);
        chk("t1_k63", outD[63], 54);
        clearQ();

        // 2: flat frame, sum mode
        sendFrame(2'b11, 10, 1, 3, 0);
        drainCompare("t2");
        clearQ();

        // 3: vertical edge, |Gx| then |Gy|
        sendFrame(2'b01, 300, 2, 3, 0);
        drainCompare("t3x");
        chk("t3_k20_data", outD[20], 400);
        chk("t3_k20_edge", outE[20], 1);
        chk("t3_k22_data", outD[22], 0);
        clearQ();
        sendFrame(2'b10, 300, 2, 3, 0);
        drainCompare("t3y");
        clearQ();

        // 4: full-scale step saturates
        sendFrame(2'b11, 4095, 3, 3, 0);
        drainCompare("t4");
        chk("t4_k20_data", outD[20], 4095);
        chk("t4_k20_edge", outE[20], 1);
        clearQ();

        // 5: gapped input matches gapless; SOF mid-line restarts accounting
        sendFrame(2'b11, 200, 4, 4, 0);
        drainCompare("t5a");
        savedD = outD;
        clearQ();
        sendFrame(2'b11, 200, 4, 4, 2);
        drainCompare("t5b");
        chk("t5_same_count", outD.size(), savedD.size());
        for (int i = 0; i < outD.size() && i < savedD.size(); i++)
            chk($sformatf("t5_same%0d", i), outD[i], savedD[i]);
        clearQ();
        modeT = 2'b11;
        thrT  = 200;
        for (int k = 0; k < 5; k++)
            sendPix(k == 0, pat(4, 0, k), 1'b1, 0);
        sendFrame(2'b11, 200, 4, 3, 0);
        drainCompare("t5c");
        chk("t5_row1_col7", outD[5 + 15], 0);
        clearQ();

        // 6: reset with pixels in flight
        modeT = 2'b11;
        thrT  = 0;
        for (int k = 0; k < 5; k++)
            sendPix(k == 0, pat(0, 2, k), 1'b0, 0);
        @(negedge iCLK);
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        #2 iRST = 1'b0;
        #1;
        chk("t6_rst_dval", int'(oDVAL), 0);
        chk("t6_rst_data", int'(oDATA), 0);
        chk("t6_rst_edge", int'(oEDGE), 0);
        clearQ();
        br = 0;
        bc = 0;
        modeT = 2'b00;
        thrT  = 0;
        @(negedge iCLK);
        iRST = 1'b1;
        idle(8);
        chk("t6_no_output", outD.size(), 0);
        for (int k = 0; k < 3 * IW; k++)
            sendPix(1'b0, pat(0, k / IW, k % IW), 1'b1, 0);
        drainCompare("t6");
        chk("t6_k18_bypass", outD[18], 9);
        clearQ();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
